// File: rtl/opll_bus_pkg.sv
// rtl/opll_bus_pkg.sv - shared types, default timing and bus drive decode for the OPLL bus writer
package opll_bus_pkg;

  localparam int DEF_ADDR_WAIT = 12;
  localparam int DEF_DATA_WAIT = 84;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_STROBE,
    ST_A_HOLD,
    ST_A_WAIT,
    ST_D_SETUP,
    ST_D_STROBE,
    ST_D_HOLD,
    ST_D_WAIT
  } state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  typedef struct packed {
    logic       cs_n;
    logic       wr_n;
    logic       a0;
    logic       d_oe;
    logic [7:0] d;
  } bus_t;

  localparam bus_t BUS_IDLE = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bus pin values for the state being entered; wait states fall through to BUS_IDLE.
  function automatic bus_t bus_drive(input state_t s, input req_t r);
    bus_t b;
    b = BUS_IDLE;
    if (s inside {ST_A_SETUP, ST_A_STROBE, ST_A_HOLD}) begin
      b.a0   = 1'b0;
      b.d    = r.addr;
      b.d_oe = 1'b1;
      b.cs_n = (s == ST_A_HOLD);
      b.wr_n = (s != ST_A_STROBE);
    end else if (s inside {ST_D_SETUP, ST_D_STROBE, ST_D_HOLD}) begin
      b.a0   = 1'b1;
      b.d    = r.data;
      b.d_oe = 1'b1;
      b.cs_n = (s == ST_D_HOLD);
      b.wr_n = (s != ST_D_STROBE);
    end
    return b;
  endfunction

endpackage

// File: rtl/opll_bus_fifo.sv
// rtl/opll_bus_fifo.sv - request FIFO holding packed {addr,data} entries ahead of the bus sequencer
module opll_bus_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        i_EMUCLK,
  input  logic        i_RST,
  input  logic        i_PUSH,
  input  logic [15:0] i_PUSH_DATA,
  input  logic        i_POP,
  output logic [15:0] o_POP_DATA,
  output logic        o_FULL,
  output logic        o_EMPTY
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [15:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign o_EMPTY    = (wr_ptr == rd_ptr);
  assign o_FULL     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_POP_DATA = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (i_PUSH && !o_FULL)  wr_ptr <= wr_ptr + PTR_ONE;
      if (i_POP  && !o_EMPTY) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_PUSH && !o_FULL) mem[wr_ptr[AW-1:0]] <= i_PUSH_DATA;
  end

endmodule

// File: rtl/opll_bus_writer.sv
// rtl/opll_bus_writer.sv - queued OPLL register writer; OPLL_BUS_WRITER_SKIP_REDUNDANT_ADDR_EN skips repeated address phases
module opll_bus_writer
  import opll_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WAIT  = DEF_ADDR_WAIT,
  parameter int DATA_WAIT  = DEF_DATA_WAIT
) (
  input  logic       i_EMUCLK,
  input  logic       i_RST,
  input  logic       i_phiM_PCEN_n,
  input  logic       i_REQ_VALID,
  output logic       o_REQ_READY,
  input  logic [7:0] i_REQ_ADDR,
  input  logic [7:0] i_REQ_DATA,
  output logic       o_CS_n,
  output logic       o_WR_n,
  output logic       o_A0,
  output logic [7:0] o_D,
  output logic       o_D_OE,
  output logic       o_BUSY
);

  localparam int CNT_W = $clog2(max_int(ADDR_WAIT, DATA_WAIT) + 1);
  localparam logic [CNT_W-1:0] A_LOAD  = CNT_W'(ADDR_WAIT - 1);
  localparam logic [CNT_W-1:0] D_LOAD  = CNT_W'(DATA_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  req_t             cur, cur_nxt, head_req;
  bus_t             bus_q;
  logic [15:0]      head;
  logic             fifo_full, fifo_empty, pop, push, tick, ready_en, skip_addr;

  assign tick        = !i_phiM_PCEN_n;
  assign o_REQ_READY = ready_en && !fifo_full;
  assign push        = i_REQ_VALID && o_REQ_READY;
  assign head_req    = head;

  opll_bus_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_EMUCLK   (i_EMUCLK),
    .i_RST      (i_RST),
    .i_PUSH     (push),
    .i_PUSH_DATA({i_REQ_ADDR, i_REQ_DATA}),
    .i_POP      (pop),
    .o_POP_DATA (head),
    .o_FULL     (fifo_full),
    .o_EMPTY    (fifo_empty)
  );

`ifdef OPLL_BUS_WRITER_SKIP_REDUNDANT_ADDR_EN
  logic [7:0] last_addr;
  logic       last_valid;

  assign skip_addr = last_valid && (head_req.addr == last_addr);

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      last_valid <= 1'b0;
      last_addr  <= 8'h00;
    end else if (tick && state == ST_A_SETUP) begin
      last_valid <= 1'b1;
      last_addr  <= cur.addr;
    end
  end
`else
  assign skip_addr = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cur_nxt   = cur;
    pop       = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            cur_nxt   = head_req;
            state_nxt = skip_addr ? ST_D_SETUP : ST_A_SETUP;
          end
        end
        ST_A_SETUP:  state_nxt = ST_A_STROBE;
        ST_A_STROBE: state_nxt = ST_A_HOLD;
        ST_A_HOLD: begin
          state_nxt = ST_A_WAIT;
          cnt_nxt   = A_LOAD;
        end
        ST_A_WAIT: begin
          if (cnt == '0) state_nxt = ST_D_SETUP;
          else           cnt_nxt   = cnt - CNT_ONE;
        end
        ST_D_SETUP:  state_nxt = ST_D_STROBE;
        ST_D_STROBE: state_nxt = ST_D_HOLD;
        ST_D_HOLD: begin
          state_nxt = ST_D_WAIT;
          cnt_nxt   = D_LOAD;
        end
        ST_D_WAIT: begin
          if (cnt == '0) state_nxt = ST_IDLE;
          else           cnt_nxt   = cnt - CNT_ONE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Pins are registered from the next state so they change in step with the FSM.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cur      <= '0;
      bus_q    <= BUS_IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur      <= cur_nxt;
      bus_q    <= bus_drive(state_nxt, cur_nxt);
      ready_en <= 1'b1;
    end
  end

  assign o_CS_n = bus_q.cs_n;
  assign o_WR_n = bus_q.wr_n;
  assign o_A0   = bus_q.a0;
  assign o_D    = bus_q.d;
  assign o_D_OE = bus_q.d_oe;
  assign o_BUSY = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_opll_bus_writer.sv
// tb/tb_opll_bus_writer.sv - scoreboard bench for opll_bus_writer (honours OPLL_BUS_WRITER_SKIP_REDUNDANT_ADDR_EN)
module tb_opll_bus_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pcen_n = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, cs_n, wr_n, a0, d_oe, busy;
  logic [7:0] d;

  opll_bus_writer dut (
    .i_EMUCLK     (clk),
    .i_RST        (rst),
    .i_phiM_PCEN_n(pcen_n),
    .i_REQ_VALID  (req_valid),
    .o_REQ_READY  (req_ready),
    .i_REQ_ADDR   (req_addr),
    .i_REQ_DATA   (req_data),
    .o_CS_n       (cs_n),
    .o_WR_n       (wr_n),
    .o_A0         (a0),
    .o_D          (d),
    .o_D_OE       (d_oe),
    .o_BUSY       (busy)
  );

  typedef struct {
    bit         is_idle;
    logic       a0;
    logic [7:0] d;
    int         gap;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  tick_en = 1'b0;
  bit  div     = 1'b0;
  int  tick_cnt = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  initial forever #5 clk = ~clk;

  // One phiM tick every other EMUCLK cycle while enabled.
  initial forever begin
    @(negedge clk);
    div    = ~div;
    pcen_n = !(tick_en && div);
  end

  initial forever begin
    @(posedge clk);
    if (!rst && !pcen_n) tick_cnt++;
  end

  // Monitor: every WR_n falling edge and every BUSY falling edge pops one expectation.
  initial begin
    logic prev_wr;
    logic prev_busy;
    int   last_strobe;
    int   low_start;
    ev_t  ev;
    prev_wr = 1'b1; prev_busy = 1'b0; last_strobe = 0; low_start = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wr = 1'b1;
        prev_busy = 1'b0;
      end else begin
        if (prev_wr && !wr_n) begin
          low_start = tick_cnt;
          if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
          else begin
            ev = exp_q.pop_front();
            chk("strobe_kind", int'(ev.is_idle), 0);
            chk("strobe_a0", int'(a0), int'(ev.a0));
            chk("strobe_d", int'(d), int'(ev.d));
            chk("strobe_cs_n", int'(cs_n), 0);
            chk("strobe_d_oe", int'(d_oe), 1);
            if (ev.gap >= 0) chk("strobe_gap", tick_cnt - last_strobe, ev.gap);
          end
          last_strobe = tick_cnt;
        end
        if (!prev_wr && wr_n) chk("strobe_len", tick_cnt - low_start, 1);
        if (prev_busy && !busy) begin
          if (exp_q.size() == 0) chk("unexpected_idle", 1, 0);
          else begin
            ev = exp_q.pop_front();
            chk("idle_kind", int'(ev.is_idle), 1);
            chk("idle_gap", tick_cnt - last_strobe, ev.gap);
          end
        end
        prev_wr = wr_n;
        prev_busy = busy;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic exp_strobe(input logic a0v, input logic [7:0] dv, input int gap);
    ev_t e;
    e.is_idle = 1'b0; e.a0 = a0v; e.d = dv; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic exp_idle(input int gap);
    ev_t e;
    e.is_idle = 1'b1; e.a0 = 1'b0; e.d = 8'h00; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] dv);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("push_timeout", 0, 1);
    else begin
      req_valid = 1'b1; req_addr = a; req_data = dv;
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    @(negedge clk); #1;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_wr_n", int'(wr_n), 1);
    chk("rst_a0", int'(a0), 0);
    chk("rst_d", int'(d), 0);
    chk("rst_d_oe", int'(d_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(req_ready), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", int'(req_ready), 1);

    // Single write: address strobe, data 15 ticks later, idle 86 ticks after that.
    tick_en = 1'b1;
    exp_strobe(1'b0, 8'h00, -1);
    exp_strobe(1'b1, 8'h7A, 15);
    exp_idle(86);
    push(8'h00, 8'h7A);
    drain("single_drain");

    // Back-to-back: second address strobe 88 ticks after the first data strobe, busy never drops.
    exp_strobe(1'b0, 8'h10, -1);
    exp_strobe(1'b1, 8'h20, 15);
    exp_strobe(1'b0, 8'h30, 88);
    exp_strobe(1'b1, 8'h0F, 15);
    exp_idle(86);
    push(8'h10, 8'h20);
    push(8'h30, 8'h0F);
    drain("b2b_drain");

    // Fill the FIFO with no ticks; the fifth request must be refused.
    tick_en = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      exp_strobe(1'b0, 8'(8'h41 + i), (i == 0) ? -1 : 88);
      exp_strobe(1'b1, 8'(8'h11 * (i + 1)), 15);
      push(8'(8'h41 + i), 8'(8'h11 * (i + 1)));
      chk("ready_after_push", int'(req_ready), (i < 3) ? 1 : 0);
    end
    exp_idle(86);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 8'h55; req_data = 8'h99;
    repeat (4) @(posedge clk);
    #1;
    chk("full_ready", int'(req_ready), 0);
    chk("full_cs_n", int'(cs_n), 1);
    chk("full_wr_n", int'(wr_n), 1);
    chk("full_busy", int'(busy), 1);
    @(negedge clk) req_valid = 1'b0;
    tick_en = 1'b1;
    drain("full_drain");

    // Reset during the data strobe drops the bus at once and discards the queued request.
    exp_strobe(1'b0, 8'h50, -1);
    push(8'h50, 8'hAA);
    push(8'h51, 8'hBB);
    begin
      int n;
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!(!wr_n && a0) && n < 500);
      chk("reach_d_strobe", int'(!wr_n && a0), 1);
    end
    rst = 1'b1;
    #1;
    chk("abort_wr_n", int'(wr_n), 1);
    chk("abort_cs_n", int'(cs_n), 1);
    chk("abort_d_oe", int'(d_oe), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(req_ready), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_abort", int'(req_ready), 1);
    repeat (400) @(negedge clk);
    #1;
    chk("abort_quiet_busy", int'(busy), 0);
    chk("abort_quiet_queue", exp_q.size(), 0);

    // Repeated address: one pulse when redundant address phases are skipped, two otherwise.
    exp_strobe(1'b0, 8'h20, -1);
    exp_strobe(1'b1, 8'h01, 15);
`ifdef OPLL_BUS_WRITER_SKIP_REDUNDANT_ADDR_EN
    exp_strobe(1'b1, 8'h02, 88);
`else
    exp_strobe(1'b0, 8'h20, 88);
    exp_strobe(1'b1, 8'h02, 15);
`endif
    exp_idle(86);
    push(8'h20, 8'h01);
    push(8'h20, 8'h02);
    drain("repeat_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
